// File: rtl/bram_rd_pkg.sv
// Shared types and default sizes for the BRAM stream reader.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int RD_ADDR_W = 4;
  localparam int RD_DATA_W = 16;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready output stream of the BRAM reader; m_last exists only when
// BRAM_READER_LAST_EN is defined.
interface bram_stream_reader_if #(
  parameter int DATA_W = 16
);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
`ifdef BRAM_READER_LAST_EN
  logic              m_last;
`endif

`ifdef BRAM_READER_LAST_EN
  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
`else
  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
`endif

endinterface

// File: rtl/bram_rd_fifo2.sv
// Two-entry register FIFO absorbing the BRAM read latency; carries a last tag
// per entry when BRAM_READER_LAST_EN is defined.
module bram_rd_fifo2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] in_data,
`ifdef BRAM_READER_LAST_EN
  input  logic              in_last,
  output logic              out_last,
`endif
  input  logic              pop,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] data_q [2];
`ifdef BRAM_READER_LAST_EN
  logic              last_q [2];
`endif
  logic              wr_q;
  logic              rd_q;
  logic [1:0]        occ_q;

  // Push into a full FIFO is only legal together with a pop; the issue rule
  // upstream guarantees that, so no full guard is needed here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
`ifdef BRAM_READER_LAST_EN
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
`endif
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_q] <= in_data;
`ifdef BRAM_READER_LAST_EN
        last_q[wr_q] <= in_last;
`endif
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_data = data_q[rd_q];
`ifdef BRAM_READER_LAST_EN
  assign out_last = last_q[rd_q];
`endif
  assign occ      = occ_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Port-B read controller streaming a wrap-around block of BRAM words.
// Optional m_last tagging is enabled with BRAM_READER_LAST_EN.
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int ADDR_W = RD_ADDR_W,
  parameter int DATA_W = RD_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    len,
  output logic [ADDR_W-1:0]    addrb,
  input  logic [DATA_W-1:0]    doutb,
  output logic                 busy,
  output logic                 done,
  bram_stream_reader_if.master m
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] issue_cnt_q;
  logic [ADDR_W-1:0] pop_cnt_q;
  logic              pend_q;
  logic              done_q;
  logic [1:0]        occ;
  logic [2:0]        fill;
  logic              pop, issue, last_issue, last_pop, take;
`ifdef BRAM_READER_LAST_EN
  logic              pend_last_q;
`endif

  assign pop  = m.m_valid & m.m_ready;
  // Words already buffered or in flight, net of the one leaving this cycle.
  assign fill = {1'b0, occ} + {2'b0, pend_q} - {2'b0, pop};

  always_comb begin
    state_d    = state_q;
    take       = 1'b0;
    issue      = 1'b0;
    last_issue = 1'b0;
    last_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          take    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        issue      = (fill < 3'd2);
        last_issue = issue && (issue_cnt_q == '0);
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        last_pop = pop && (pop_cnt_q == '0);
        if (last_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BRAM_READER_LAST_EN
      pend_last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= issue;
      done_q  <= last_pop;
`ifdef BRAM_READER_LAST_EN
      pend_last_q <= last_issue;
`endif
      if (take) begin
        addr_q      <= base_addr;
        issue_cnt_q <= len;
        pop_cnt_q   <= len;
      end else begin
        if (issue) addr_q <= addr_q + 1'b1;
        if (issue && !last_issue) issue_cnt_q <= issue_cnt_q - 1'b1;
        if (pop && pop_cnt_q != '0) pop_cnt_q <= pop_cnt_q - 1'b1;
      end
    end
  end

  // BRAM data lands one cycle after the issue and is pushed on the following edge.
  bram_rd_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pend_q),
    .in_data  (doutb),
`ifdef BRAM_READER_LAST_EN
    .in_last  (pend_last_q),
    .out_last (m.m_last),
`endif
    .pop      (pop),
    .out_data (m.m_data),
    .occ      (occ)
  );

  assign m.m_valid = (occ != 2'd0);
  assign addrb     = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural 16x16 BRAM on port B.
`timescale 1ns/1ps
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [3:0]  len = '0;
  logic [3:0]  addrb;
  logic [15:0] doutb = '0;
  logic        busy, done;
  logic [15:0] mem [16];
  int          n_chk = 0;
  int          n_err = 0;

  bram_stream_reader_if #(.DATA_W(16)) s ();

  bram_stream_reader #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .addrb     (addrb),
    .doutb     (doutb),
    .busy      (busy),
    .done      (done),
    .m         (s.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) doutb <= mem[addrb];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for the first 10 cycles
  task automatic run_burst(input logic [3:0] b, input logic [3:0] l, input int mode, input bit mid);
    int k, first_i, last_i, done_i, done_n, lead;
    bit stall;
    logic [15:0] pdat;
    logic [3:0]  ea, issued;
    k = 0; first_i = -1; last_i = -1; done_i = -1; done_n = 0; stall = 0; pdat = '0;
    base_addr = b; len = l; start = 1'b1; s.m_ready = (mode == 0);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 200; i++) begin
      case (mode)
        0:       s.m_ready = 1'b1;
        1:       s.m_ready = 1'($urandom_range(0, 1));
        default: s.m_ready = (i >= 10);
      endcase
      if (mid && i == 3) begin
        start = 1'b1; base_addr = 4'd5; len = 4'd15;
      end
      #1;
      if (done) begin done_n++; done_i = i; end
      ea = b + 4'(i);
      if (mode == 0 && i <= int'(l)) chk("addrb", addrb, ea);
      if (mode == 2 && i == 10) begin
        chk("held_addr", addrb, b + 4'd2);
        chk("held_valid", s.m_valid, 1);
        chk("held_data", s.m_data, 16'hA000 + 16'(b));
      end
      if (mode == 1) begin
        issued = addrb - b;
        lead = int'(issued) - k;
        chk("lead", lead <= 2, 1);
      end
      if (stall) begin
        chk("stall_valid", s.m_valid, 1);
        chk("stall_data", s.m_data, pdat);
      end
      stall = s.m_valid && !s.m_ready;
      pdat  = s.m_data;
      if (s.m_valid && s.m_ready) begin
        if (first_i < 0) first_i = i;
        last_i = i;
        ea = b + 4'(k);
        chk("data", s.m_data, 16'hA000 + 16'(ea));
`ifdef BRAM_READER_LAST_EN
        chk("last", s.m_last, k == int'(l));
`endif
        k++;
      end
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (done_n > 0 && i > done_i + 2) break;
    end
    s.m_ready = 1'b0;
    chk("count", k, int'(l) + 1);
    chk("done_once", done_n, 1);
    chk("busy_end", busy, 0);
    if (mode == 0) begin
      chk("latency", first_i, 2);
      chk("done_at", done_i, last_i + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
    s.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addrb", addrb, 0);
    chk("rst_valid", s.m_valid, 0);
    chk("rst_data", s.m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_burst(4'd0, 4'd15, 0, 1'b0);
    run_burst(4'd14, 4'd3, 0, 1'b0);
    run_burst(4'd2, 4'd7, 1, 1'b0);
    run_burst(4'd0, 4'd5, 2, 1'b0);
    run_burst(4'd9, 4'd7, 0, 1'b1);

    // Reset in the middle of a full-memory burst.
    base_addr = 4'd0; len = 4'd15; start = 1'b1; s.m_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", s.m_valid, 0);
    chk("midrst_data", s.m_data, 0);
    chk("midrst_addrb", addrb, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
`ifdef BRAM_READER_LAST_EN
    chk("midrst_last", s.m_last, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_burst(4'd0, 4'd3, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side controller for the 16-deep × 16-bit simple dual-port `bRAM`. It drives port B (`addrb`/`doutb`) and streams a contiguous, wrap-around block of words out on a valid/ready interface. A 2-entry output buffer absorbs the BRAM's 1-cycle read latency, so backpressure never drops or duplicates a word. It sits between the BRAM and any consumer, such as a display or serializer, while port A remains owned by the writer.

## Interface
- `ADDR_W`, 4: BRAM address width; depth is 2^ADDR_W.
- `DATA_W`, 16: BRAM word width.
- `clk` in 1: single clock, shared with the BRAM's `clkb`.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: command strobe; sampled only in IDLE.
- `base_addr` in ADDR_W: first address, captured on `start`.
- `len` in ADDR_W: word count minus 1, captured on `start`; a burst is 1..2^ADDR_W words.
- `addrb` out ADDR_W: BRAM port-B address.
- `doutb` in DATA_W: BRAM port-B data; valid the cycle after `addrb` is sampled.
- `m_valid` out 1: output word available.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out DATA_W: output word.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse after the last word handshakes.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN: on `start`. Captures `base_addr` into the address counter, captures `len` into the issue and pop counters, and asserts `busy`.
  - RUN→DRAIN: when the last address is issued.
  - DRAIN→IDLE: when the last word is popped. `done` pulses for one cycle and `busy` deasserts in that same cycle.
- `start` outside IDLE is ignored.
- `addrb` always equals the address counter register. An issue in cycle c means the BRAM samples `addrb` at the end of c.
  - The counter increments modulo 2^ADDR_W on each issue. Example: base 14, len 3 reads 14, 15, 0, 1.
- Pending flag `pend_q` is set on issue. `doutb` is captured into the buffer at the end of the next cycle.
- Issue rule: in RUN, issue iff `occ + pend_q − pop < 2`, where `pop = m_valid & m_ready`. This gives 1 word/cycle sustained while `m_ready` is held high.
- Buffer:
  - 2-entry FIFO; `m_valid = (occ != 0)`; `m_data` is the head entry.
  - `m_data` is stable while `m_valid & !m_ready`.
  - Push and pop in the same cycle are legal, including when the buffer is full, because pop frees the slot.
- `len` = 2^ADDR_W−1 reads the whole memory exactly once; the address wraps back to base.
- Reset values: `addrb`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0. State=IDLE, occ=0, `pend_q`=0. Reset mid-burst discards all in-flight words immediately.

## Timing
- `start` is sampled at edge E0.
- `addrb`=base during cycle E0→E1.
- First `m_valid` goes high after E2, so start-to-first-word latency is 2 cycles.
- With `m_ready` held high, an N-word burst shows `m_valid` for N consecutive cycles. `done` pulses in the cycle after the final handshake edge.
- With `m_ready` held low, at most 2 words are fetched and nothing further is issued until a pop.

## Configuration
- `BRAM_READER_LAST_EN`:
  - Defined: adds output `m_last` (1 bit). It is high together with `m_valid` on the final word of a burst; each buffer entry carries a last bit. `m_last` resets to 0.
  - Undefined: no `m_last` port and no last-tag storage; all other behaviour is identical.

## Structure
- Package `bram_rd_pkg`: the state enum (IDLE/RUN/DRAIN) and the default ADDR_W/DATA_W constants.
- Sub-module `bram_rd_fifo2`:
  - 2-entry register FIFO with push/pop/occ and a DATA_W payload.
  - Carries the +1 last bit when `BRAM_READER_LAST_EN` is defined.

## Test plan
- Preload mem[i]=0xA000+i; base 0, len 15, `m_ready`=1 → words 0xA000..0xA00F on 16 consecutive cycles, first one 2 cycles after the start edge, then `done` pulses once.
- Base 14, len 3 → `addrb` sequence 14, 15, 0, 1; output data 0xA00E, 0xA00F, 0xA000, 0xA001.
- `m_ready` random at 50%, len 7 → exactly 8 words in order with no duplicates, `m_data` stable whenever stalled, and at most 2 issues beyond the pops at any time.
- `m_ready`=0 for 10 cycles after start → exactly 2 issues, `m_valid` held with data 0xA000. Releasing `m_ready` then completes the burst correctly.
- `start` pulsed mid-burst → ignored; the burst length is unchanged.
- `rst_n` low mid-burst → all outputs 0 immediately. A new start after release runs cleanly. With `BRAM_READER_LAST_EN` defined, `m_last` is high only on the final word.
